// File: rtl/cla_add32_pipe.sv
// Two-stage pipelined 32-bit adder built from two 16-bit carry-lookahead halves.
// Optional signed-overflow output is enabled by defining CLA_PIPE_OVF_EN.

module cla_adder16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  localparam int unsigned W  = 16;
  localparam int unsigned GW = 4;
  localparam int unsigned NG = W / GW;

  logic [W-1:0]  w_g;
  logic [W-1:0]  w_p;
  logic [W:0]    w_c;
  logic [NG-1:0] w_gg;
  logic [NG-1:0] w_gp;
  logic [NG:0]   w_gc;

  // Per-group generate/propagate, then lookahead across the four groups.
  always_comb begin
    w_g  = i_a & i_b;
    w_p  = i_a ^ i_b;
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    for (int j = 0; j < int'(NG); j++) begin
      w_gg[j] = w_g[GW*j+3]
              | (w_p[GW*j+3] & w_g[GW*j+2])
              | (w_p[GW*j+3] & w_p[GW*j+2] & w_g[GW*j+1])
              | (w_p[GW*j+3] & w_p[GW*j+2] & w_p[GW*j+1] & w_g[GW*j]);
      w_gp[j] = &w_p[GW*j +: GW];
    end
    w_gc[0] = i_cin;
    w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    for (int j = 0; j < int'(NG); j++) begin
      w_c[GW*j] = w_gc[j];
      for (int i = 0; i < int'(GW) - 1; i++) begin
        w_c[GW*j+i+1] = w_g[GW*j+i] | (w_p[GW*j+i] & w_c[GW*j+i]);
      end
    end
    w_c[W] = w_gc[NG];
  end

  assign o_sum  = w_p ^ w_c[W-1:0];
  assign o_cout = w_c[W];

endmodule

module cla_add32_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        ovf
);

  localparam int unsigned HW = 16;

  logic [HW-1:0] r_s1_sum_lo;
  logic          r_s1_c16;
  logic [HW-1:0] r_s1_a_hi;
  logic [HW-1:0] r_s1_b_hi;
  logic          r_s1_valid;
  logic [31:0]   r_sum;
  logic          r_carry_out;
  logic          r_out_valid;

  logic [HW-1:0] w_lo_sum;
  logic          w_lo_cout;
  logic [HW-1:0] w_hi_sum;
  logic          w_hi_cout;
  logic          w_s2_free;
  logic          w_accept;
  logic          w_xfer;

  cla_adder16 lo (
    .i_a    (a[HW-1:0]),
    .i_b    (b[HW-1:0]),
    .i_cin  (carry_in),
    .o_sum  (w_lo_sum),
    .o_cout (w_lo_cout)
  );

  cla_adder16 hi (
    .i_a    (r_s1_a_hi),
    .i_b    (r_s1_b_hi),
    .i_cin  (r_s1_c16),
    .o_sum  (w_hi_sum),
    .o_cout (w_hi_cout)
  );

  // No skid buffer: S1 can take a beat only if it is empty or draining this cycle.
  assign w_s2_free = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_s1_valid && w_s2_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sum_lo <= '0;
      r_s1_c16    <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_sum_lo <= w_lo_sum;
      r_s1_c16    <= w_lo_cout;
      r_s1_a_hi   <= a[31:HW];
      r_s1_b_hi   <= b[31:HW];
    end else if (w_xfer) begin
      r_s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_sum       <= {w_hi_sum, r_s1_sum_lo};
      r_carry_out <= w_hi_cout;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic [1:0] r_s1_sgn;
  logic       r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sgn <= '0;
    end else if (w_accept) begin
      r_s1_sgn <= {a[31], b[31]};
    end
  end

  // Overflow: operands share a sign that the result does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      r_ovf <= (r_s1_sgn[1] == r_s1_sgn[0]) && (w_hi_sum[HW-1] != r_s1_sgn[1]);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_cla_add32_pipe.sv
// Self-checking bench for cla_add32_pipe: directed vector table, back-pressure,
// reset and randomized traffic against an arithmetic reference queue.

module tb_cla_add32_pipe;

`ifdef CLA_PIPE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry_out;
  logic        ovf;

  cla_add32_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    res_t        exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  res_t q[$];
  bit   hold_pending = 1'b0;
  logic [31:0] held_sum;
  logic        held_co;
  logic        held_ovf;
  bit   last_acc;
  bit   last_deq;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] t;
    res_t r;
    t = 33'(x) + 33'(y) + 33'(c);
    r.sum = t[31:0];
    r.co  = t[32];
    r.ovf = OVF_EN && (x[31] == y[31]) && (t[31] != x[31]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: scoreboard at the falling edge, then return just after the rising edge.
  task automatic step();
    res_t e;
    @(negedge clk);
    last_acc = 1'b0;
    last_deq = 1'b0;
    if (rst_n) begin
      if (hold_pending) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", sum, held_sum);
        chk("hold_co", 32'(carry_out), 32'(held_co));
        chk("hold_ovf", 32'(ovf), 32'(held_ovf));
      end
      hold_pending = out_valid && !out_ready;
      held_sum = sum;
      held_co  = carry_out;
      held_ovf = ovf;
      if (out_valid && out_ready) begin
        last_deq = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_sum", sum, e.sum);
          chk("sb_co", 32'(carry_out), 32'(e.co));
          chk("sb_ovf", 32'(ovf), 32'(e.ovf));
        end
      end
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        q.push_back(model(a, b, carry_in));
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  logic [31:0] corners[6];

  initial begin
    vecs[0] = '{32'd10, 32'd22, 1'b0, '{32'd32, 1'b0, 1'b0}};
    vecs[1] = '{32'd10, 32'd22, 1'b1, '{32'd33, 1'b0, 1'b0}};
    vecs[2] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, '{32'h0001_0000, 1'b0, 1'b0}};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b0}};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, OVF_EN}};
    vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, OVF_EN}};
    vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, '{32'hACF1_3568, 1'b0, 1'b0}};
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h0000_FFFF;
    corners[5] = 32'hFFFF_0000;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_co", 32'(carry_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with latency check.
    foreach (vecs[i]) begin
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; carry_in = vecs[i].ci;
      step();
      chk("acc", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
      chk("lat_s1_only", 32'(out_valid), 32'd0);
      step();
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("vec_sum", sum, vecs[i].exp.sum);
      chk("vec_co", 32'(carry_out), 32'(vecs[i].exp.co));
      chk("vec_ovf", 32'(ovf), 32'(vecs[i].exp.ovf));
      step();
    end

    // Back-pressure: two beats fill the pipe, the rest wait for release.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd1; b = 32'd100; carry_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (last_acc) a = a + 32'd1;
    end
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_sum", sum, 32'd101);
    chk("bp_next_beat", a, 32'd3);
    out_ready = 1'b1;
    begin
      int deqs;
      deqs = 0;
      for (int k = 0; k < 4; k++) begin
        step();
        if (last_deq) deqs++;
        if (last_acc) a = a + 32'd1;
        if (a > 32'd4) in_valid = 1'b0;
      end
      chk("bp_no_gaps", 32'(deqs), 32'd4);
    end
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Randomized traffic with random stalls and corner operands.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a = (($urandom % 4) == 0) ? corners[$urandom % 6] : $urandom;
      b = (($urandom % 4) == 0) ? corners[$urandom % 6] : $urandom;
      carry_in = 1'($urandom % 2);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) step();
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd7; b = 32'd8; carry_in = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", sum, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    hold_pending = 1'b0;
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; a = 32'd5; b = 32'd6; carry_in = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_sum", sum, 32'd11);
    step();
    chk("post_rst_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
